pattern_detector_7seg: RTL and testbench
========================================

// Module: pattern_detector_7seg
// PURPOSE
//  Parametrised serial pattern detector: a 1-bit stream is compared against a loadable
//  PAT_W-bit target; each hit pulses `match` and bumps a match counter. The counter's low
//  nibble drives a hex 7-segment digit (a..g), so it plugs directly into the board display path.
//  Generalises the fixed 4-bit identifier: width parameter, overlap mode, history fill tracking.
// PARAMETERS
//  PAT_W   4   target pattern width in bits (2..16)
//  CNT_W   8   match counter width (>=4); display shows count[3:0]
// PORTS
//  clock        in   1      system clock, all logic on rising edge
//  reset        in   1      synchronous, active-low reset
//  pattern      in   PAT_W  target pattern; sampled only when pat_load=1
//  pat_load     in   1      load `pattern` as target, clear stream history
//  bit_in       in   1      serial data bit
//  bit_valid    in   1      bit_in is consumed this cycle
//  overlap      in   1      1: overlapping matches allowed; 0: history cleared after each match
//  match        out  1      one-cycle pulse, registered
//  match_count  out  CNT_W  number of matches since reset
//  a,b,c,d,e,f,g out 1 each hex segments of match_count[3:0], active-high
// BEHAVIOUR
//  - Reset (reset=0 at edge): target=0, shift=0, fill=0, state=FILL, match=0, match_count=0;
//    segments therefore show "0": a..f=1, g=0. Reset overrides every other input.
//  - Bit order: first-received bit is target MSB; shift <= {shift[PAT_W-2:0], bit_in}.
//  - fill counts valid bits since last clear, saturating at PAT_W.
//  - States: FILL (fill<PAT_W, no match possible) -> ARMED when fill reaches PAT_W.
//  - Match test on a cycle with bit_valid=1 uses the NEW shift value: {shift[PAT_W-2:0],bit_in}
//    == target and (state==ARMED or fill==PAT_W-1). Hit -> match=1 on the next cycle
//    (latency 1 from the completing bit's edge), match_count increments on that same edge.
//  - After a hit: overlap=1 -> stay ARMED, shift keeps new value. overlap=0 -> shift=0, fill=0,
//    state=FILL (next match needs PAT_W fresh bits).
//  - match is 0 on every cycle not directly following a hit; bit_valid=0 holds all state.
//  - pat_load=1: target<=pattern, shift=0, fill=0, state=FILL, match=0; bit_in ignored that
//    cycle even if bit_valid=1 (load wins). match_count is NOT cleared by pat_load.
//  - Changes on `pattern` while pat_load=0 have no effect.
//  - overlap sampled per cycle; changing it mid-stream affects only the next hit.
//  - match_count default wraps modulo 2^CNT_W (0xFF+1 -> 0x00).
//  - Segment decode (abcdefg, combinational from match_count[3:0] register, same cycle):
//    0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=1011111 7=1110000
//    8=1111111 9=1111011 A=1110111 b=0011111 C=1001110 d=0111101 E=1001111 F=1000111
// CONFIGURATION
//  MATCH_SAT_EN defined: match_count saturates at 2^CNT_W-1; further hits still pulse `match`
//    but count holds. Undefined (default): count wraps to 0 as above.
// TESTING
//  1. Reset low 2 cycles -> match=0, match_count=0, a..g=1111110.
//  2. Load 1011, overlap=1, stream 1,0,1,1,0,1,1 -> match pulses after bits 4 and 7, count=2,
//     a..g=1101101.
//  3. Load 1011, overlap=0, same stream -> single pulse after bit 4, count=1, a..g=0110000.
//  4. Stream 1,0,1 then reset low 1 cycle, reset high, bit 1 -> no match, count=0.
//  5. Load 1011 after 1,0,1 sent, then send 1 -> no match (history cleared); send 0,1,1 -> hit.
//  6. CNT_W=4, 17 hits -> default count=1 (a..g=0110000); with MATCH_SAT_EN count=15
//     (a..g=1000111), 17 match pulses in both builds.

Source files
------------

// File: rtl/pattern_detector_7seg.sv
// Serial pattern detector with loadable PAT_W-bit target, match counter and hex 7-segment output.
// Optional build macro MATCH_SAT_EN: match_count saturates at all-ones instead of wrapping.
module pattern_detector_7seg #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [PAT_W-1:0] pattern,
  input  logic             pat_load,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             overlap,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             e,
  output logic             f,
  output logic             g
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] ARMED = 1'b1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  target;
  logic [PAT_W-1:0]  shift;
  logic [PAT_W-1:0]  shift_nxt;
  logic [FILL_W-1:0] fill;
  logic [0:0]        state;
  logic              hit;

  function automatic logic [CNT_W-1:0] count_inc(input logic [CNT_W-1:0] cnt);
`ifdef MATCH_SAT_EN
    return (&cnt) ? cnt : cnt + CNT_W'(1);
`else
    return cnt + CNT_W'(1);
`endif
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  // The bit arriving this cycle completes the window when history is already PAT_W-1 deep.
  assign shift_nxt = {shift[PAT_W-2:0], bit_in};
  assign hit = bit_valid && !pat_load && (shift_nxt == target) &&
               ((state == ARMED) || (fill == FILL_LAST));

  always_ff @(posedge clock) begin
    if (!reset) begin
      target      <= '0;
      shift       <= '0;
      fill        <= '0;
      state       <= FILL;
      match       <= 1'b0;
      match_count <= '0;
    end else if (pat_load) begin
      target <= pattern;
      shift  <= '0;
      fill   <= '0;
      state  <= FILL;
      match  <= 1'b0;
    end else begin
      match <= hit;
      if (hit) match_count <= count_inc(match_count);
      if (bit_valid) begin
        if (hit && !overlap) begin
          shift <= '0;
          fill  <= '0;
          state <= FILL;
        end else begin
          shift <= shift_nxt;
          if (fill != FILL_FULL) fill <= fill + FILL_W'(1);
          state <= (fill >= FILL_LAST) ? ARMED : FILL;
        end
      end
    end
  end

  assign {a, b, c, d, e, f, g} = seg7(match_count[3:0]);

endmodule

// File: tb/tb_pattern_detector_7seg.sv
// Self-checking bench for pattern_detector_7seg against a queue-based history model.
module tb_pattern_detector_7seg;
  localparam int PAT_W = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic             pat_load = 1'b0;
  logic             bit_in = 1'b0;
  logic             bit_valid = 1'b0;
  logic             overlap = 1'b0;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             a, b, c, d, e, f, g;

  pattern_detector_7seg #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .pattern(pattern), .pat_load(pat_load),
    .bit_in(bit_in), .bit_valid(bit_valid), .overlap(overlap), .match(match),
    .match_count(match_count), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g)
  );

  always #5 clock = ~clock;

  logic [6:0] seg_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: bits received since last clear, target, count, pending pulse.
  logic             hist [$];
  logic [PAT_W-1:0] m_tgt = '0;
  int               m_cnt = 0;
  logic             m_match = 1'b0;

  function automatic int bump(input int cnt);
`ifdef MATCH_SAT_EN
    return (cnt == CMAX) ? cnt : cnt + 1;
`else
    return (cnt + 1) % (CMAX + 1);
`endif
  endfunction

  task automatic step(input logic rn, input logic pl, input logic [PAT_W-1:0] pat,
                      input logic bv, input logic bi, input logic ov);
    int v;
    logic h;
    reset = rn; pat_load = pl; pattern = pat; bit_valid = bv; bit_in = bi; overlap = ov;
    @(posedge clock);
    if (!rn) begin
      m_tgt = '0; hist.delete(); m_cnt = 0; m_match = 1'b0;
    end else if (pl) begin
      m_tgt = pat; hist.delete(); m_match = 1'b0;
    end else if (bv) begin
      hist.push_back(bi);
      if (hist.size() > PAT_W) void'(hist.pop_front());
      v = 0;
      foreach (hist[i]) v = (v << 1) | int'(hist[i]);
      h = (hist.size() == PAT_W) && (v[PAT_W-1:0] == m_tgt);
      m_match = h;
      if (h) begin
        m_cnt = bump(m_cnt);
        if (!ov) hist.delete();
      end
    end else begin
      m_match = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    do_reset(2);
    n_cmp++; if (match !== 1'b0) begin n_fail++; $display("FAIL reset_match got %b want 0", match); end
    n_cmp++; if (match_count !== '0) begin n_fail++; $display("FAIL reset_count got %0d want 0", match_count); end
    n_cmp++; if ({a,b,c,d,e,f,g} !== 7'b1111110) begin n_fail++; $display("FAIL reset_seg got %b want 1111110", {a,b,c,d,e,f,g}); end
  endtask

  task automatic run_stream(input logic ov, input logic [6:0] bits, input logic [6:0] pulses, input string nm);
    do_reset(1);
    step(1'b1, 1'b1, 4'b1011, 1'b0, 1'b0, ov);
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, 1'b0, '0, 1'b1, bits[i], ov);
      n_cmp++;
      if (match !== pulses[i] || match !== m_match) begin
        n_fail++; $display("FAIL %s_match bit%0d got %b want %b", nm, 7 - i, match, pulses[i]);
      end
    end
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, ov);
    n_cmp++; if (match !== 1'b0) begin n_fail++; $display("FAIL %s_idle got %b want 0", nm, match); end
  endtask

  task automatic test_overlap;
    run_stream(1'b1, 7'b1011011, 7'b0001001, "ovl");
    n_cmp++; if (match_count !== 4'd2) begin n_fail++; $display("FAIL ovl_count got %0d want 2", match_count); end
    n_cmp++; if ({a,b,c,d,e,f,g} !== 7'b1101101) begin n_fail++; $display("FAIL ovl_seg got %b want 1101101", {a,b,c,d,e,f,g}); end
  endtask

  task automatic test_no_overlap;
    run_stream(1'b0, 7'b1011011, 7'b0001000, "novl");
    n_cmp++; if (match_count !== 4'd1) begin n_fail++; $display("FAIL novl_count got %0d want 1", match_count); end
    n_cmp++; if ({a,b,c,d,e,f,g} !== 7'b0110000) begin n_fail++; $display("FAIL novl_seg got %b want 0110000", {a,b,c,d,e,f,g}); end
  endtask

  task automatic test_reset_midstream;
    do_reset(1);
    step(1'b1, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (match !== 1'b0) begin n_fail++; $display("FAIL rstmid_match got %b want 0", match); end
    n_cmp++; if (match_count !== '0) begin n_fail++; $display("FAIL rstmid_count got %0d want 0", match_count); end
  endtask

  task automatic test_load_clears;
    logic [2:0] tail = 3'b011;
    do_reset(1);
    step(1'b1, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (match !== 1'b0) begin n_fail++; $display("FAIL load_nomatch got %b want 0", match); end
    for (int i = 2; i >= 0; i--) step(1'b1, 1'b0, 4'b0000, 1'b1, tail[i], 1'b1);
    n_cmp++; if (match !== 1'b1) begin n_fail++; $display("FAIL load_hit got %b want 1", match); end
    n_cmp++; if (match_count !== 4'd1) begin n_fail++; $display("FAIL load_count got %0d want 1", match_count); end
  endtask

  task automatic test_count_limit;
    int pulses = 0;
    logic [2:0] rep = 3'b011;
    logic [3:0] head = 4'b1011;
    int want;
`ifdef MATCH_SAT_EN
    want = 15;
`else
    want = 1;
`endif
    do_reset(1);
    step(1'b1, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, 1'b0, '0, 1'b1, head[i], 1'b1);
      pulses += int'(match);
    end
    for (int k = 0; k < 16; k++)
      for (int i = 2; i >= 0; i--) begin
        step(1'b1, 1'b0, '0, 1'b1, rep[i], 1'b1);
        pulses += int'(match);
      end
    n_cmp++; if (pulses != 17) begin n_fail++; $display("FAIL lim_pulses got %0d want 17", pulses); end
    n_cmp++; if (int'(match_count) != want) begin n_fail++; $display("FAIL lim_count got %0d want %0d", match_count, want); end
    n_cmp++; if ({a,b,c,d,e,f,g} !== seg_tab[want]) begin n_fail++; $display("FAIL lim_seg got %b want %b", {a,b,c,d,e,f,g}, seg_tab[want]); end
  endtask

  task automatic test_random;
    do_reset(1);
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 29) == 0), PAT_W'($urandom),
           ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
      n_cmp++; if (match !== m_match) begin n_fail++; $display("FAIL rnd_match cyc%0d got %b want %b", n, match, m_match); end
      n_cmp++; if (int'(match_count) != m_cnt) begin n_fail++; $display("FAIL rnd_count cyc%0d got %0d want %0d", n, match_count, m_cnt); end
      n_cmp++; if ({a,b,c,d,e,f,g} !== seg_tab[m_cnt[3:0]]) begin n_fail++; $display("FAIL rnd_seg cyc%0d got %b want %b", n, {a,b,c,d,e,f,g}, seg_tab[m_cnt[3:0]]); end
    end
  endtask

  initial begin
    #2;
    test_reset;
    test_overlap;
    test_no_overlap;
    test_reset_midstream;
    test_load_clears;
    test_count_limit;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
